// File: rtl/pwm_cap_pkg.sv
// Shared types and default widths for the PWM duty-cycle capture block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pwm_cap_pkg;

    // Measurement FSM: idle until the first rising edge, then measure continuously.
    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } cap_state_e;

    localparam int CNT_W_DEF  = 16;
    localparam int DUTY_W_DEF = 8;

endpackage

// File: rtl/pwm_duty_capture_if.sv
// Result bundle of the PWM capture block: duty/period/high results plus status strobes.
// Latency: n/a (wires only).
// Backpressure: none; valid and overrun are single-cycle pulses, results hold until replaced.
// master: result producer (capture block)  slave: result consumer
interface pwm_duty_capture_if
    import pwm_cap_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int DUTY_W = DUTY_W_DEF
);
    logic [DUTY_W-1:0] duty_out;    // floor(high * 2^DUTY_W / period)
    logic [CNT_W-1:0]  period_out;  // last measured period, cycles
    logic [CNT_W-1:0]  high_out;    // last measured high time, cycles
    logic              valid;       // results updated this cycle
    logic              busy;        // divider running
    logic              stuck;       // last result came from a timeout
    logic              overrun;     // capture dropped, divider was busy

    modport master (output duty_out, period_out, high_out, valid, busy, stuck, overrun);
    modport slave  (input  duty_out, period_out, high_out, valid, busy, stuck, overrun);
endinterface

// File: rtl/pwm_seq_divider.sv
// Sequential restoring divider producing floor((h_i << DUTY_W) / p_i) for h_i < p_i.
// Latency: DUTY_W cycles from start_i to done_o (done_o is high in the last busy cycle).
// Backpressure: start_i is ignored while busy_o is high; caller must check busy_o.
// Ports: clk, rst_n (sync, active-low), start_i/h_i/p_i in, busy_o/done_o/quo_o out.
module pwm_seq_divider #(
    parameter int DUTY_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  h_i,
    input  logic [CNT_W-1:0]  p_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DUTY_W-1:0] quo_o
);
    localparam int IW = (DUTY_W > 1) ? $clog2(DUTY_W) : 1;

    logic              busy_q;
    logic [IW-1:0]     iter_q;
    logic [CNT_W-1:0]  rem_q;
    logic [CNT_W-1:0]  div_q;
    logic [DUTY_W-1:0] quo_q;

    logic [CNT_W:0]    rem_sh;
    logic [CNT_W-1:0]  rem_sub;
    logic [CNT_W-1:0]  rem_d;
    logic              q_bit;

    // The dividend is h << DUTY_W, so the remainder simply starts at h and a
    // zero is shifted in each step. h < p keeps the remainder below p throughout.
    always_comb begin
        rem_sh  = {rem_q, 1'b0};
        q_bit   = (rem_sh >= {1'b0, div_q});
        // Modular subtract is exact here: the true difference is below div_q.
        rem_sub = rem_sh[CNT_W-1:0] - div_q;
        rem_d   = q_bit ? rem_sub : rem_sh[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            iter_q <= '0;
            rem_q  <= '0;
            div_q  <= '0;
            quo_q  <= '0;
        end else if (busy_q) begin
            rem_q  <= rem_d;
            quo_q  <= {quo_q[DUTY_W-2:0], q_bit};
            iter_q <= iter_q + IW'(1);
            if (iter_q == IW'(DUTY_W - 1)) begin
                busy_q <= 1'b0;
            end
        end else if (start_i) begin
            busy_q <= 1'b1;
            iter_q <= '0;
            rem_q  <= h_i;
            div_q  <= p_i;
            quo_q  <= '0;
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (iter_q == IW'(DUTY_W - 1));
    assign quo_o  = {quo_q[DUTY_W-2:0], q_bit};

endmodule

// File: rtl/pwm_duty_capture.sv
// Measures period and high time of an async PWM input and reports duty on the generator's scale.
// Latency: valid SYNC_STAGES+DUTY_W+1 cycles after the pwm_in rise that closes a period.
// Backpressure: none; a capture arriving while the divider is busy is dropped with an overrun pulse.
// Ports: clk, rst_n (sync, active-low), pwm_in (async), cap (result bundle, master side).
module pwm_duty_capture
    import pwm_cap_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DUTY_W      = DUTY_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pwm_in,
    pwm_duty_capture_if.master cap
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;
    logic                   s;
    logic                   rise;

    cap_state_e        state_q, state_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  high_q, high_d;
    logic              start;
    logic              ovr_d;
    logic              timeout;

    logic              div_busy;
    logic              div_done;
    logic [DUTY_W-1:0] div_quo;

    logic [CNT_W-1:0]  cap_p_q, cap_h_q;
    logic [DUTY_W-1:0] duty_q;
    logic [CNT_W-1:0]  per_out_q, high_out_q;
    logic              stuck_q, valid_q, ovr_q;

    // Both edges come out of the same synchronizer, so their delays cancel and
    // the measured period and high time are exact.
    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            s_d_q  <= s;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            period_q <= '0;
            high_q   <= '0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            high_q   <= high_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        high_d   = high_q;
        start    = 1'b0;
        ovr_d    = 1'b0;
        timeout  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    period_d = CNT_W'(1);
                    high_d   = CNT_W'(1);
                    state_d  = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    // Counters restart on every rise whether or not the sample is kept.
                    period_d = CNT_W'(1);
                    high_d   = CNT_W'(1);
                    if (div_busy) begin
                        ovr_d = 1'b1;
                    end else begin
                        start = 1'b1;
                    end
                end else begin
                    if (period_q == CNT_MAX) begin
                        // Deferred while dividing so the two valids never collide.
                        if (!div_busy) begin
                            timeout = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        period_d = period_q + CNT_W'(1);
                    end
                    if (s && (high_q != CNT_MAX)) begin
                        high_d = high_q + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    pwm_seq_divider #(
        .DUTY_W (DUTY_W),
        .CNT_W  (CNT_W)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .h_i     (high_q),
        .p_i     (period_q),
        .busy_o  (div_busy),
        .done_o  (div_done),
        .quo_o   (div_quo)
    );

    // div_done needs busy and timeout needs !busy, so they never coincide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_p_q    <= '0;
            cap_h_q    <= '0;
            duty_q     <= '0;
            per_out_q  <= '0;
            high_out_q <= '0;
            stuck_q    <= 1'b0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ovr_q   <= ovr_d;
            if (start) begin
                cap_p_q <= period_q;
                cap_h_q <= high_q;
            end
            if (div_done) begin
                duty_q     <= div_quo;
                per_out_q  <= cap_p_q;
                high_out_q <= cap_h_q;
                stuck_q    <= 1'b0;
                valid_q    <= 1'b1;
            end else if (timeout) begin
                duty_q     <= {DUTY_W{s}};
                per_out_q  <= '0;
                high_out_q <= '0;
                stuck_q    <= 1'b1;
                valid_q    <= 1'b1;
            end
        end
    end

    assign cap.duty_out   = duty_q;
    assign cap.period_out = per_out_q;
    assign cap.high_out   = high_out_q;
    assign cap.stuck      = stuck_q;
    assign cap.busy       = div_busy;
    // Strobes are masked while reset is held so they never overlap a reset cycle.
    assign cap.valid      = valid_q & rst_n;
    assign cap.overrun    = ovr_q & rst_n;

endmodule

// File: tb/tb_pwm_duty_capture.sv
module tb_pwm_duty_capture;
    localparam int CW   = 12;
    localparam int DW   = 8;
    localparam int SS   = 2;
    localparam int MAXV = (1 << CW) - 1;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic pwm_in = 1'b0;

    always #5 clk = ~clk;

    pwm_duty_capture_if #(.CNT_W(CW), .DUTY_W(DW)) cap_if ();

    pwm_duty_capture #(
        .CNT_W       (CW),
        .DUTY_W      (DW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .cap    (cap_if)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at edge", nm, act, exp);
        end
    endfunction

    // ---------------- behavioural model ----------------
    // Works on sampled pwm_in history: a rise is a 0->1 step of the input seen
    // SS samples late; period = edges between rises, high = high cycles in that
    // window, duty = arithmetic quotient, result due DW edges after the capture.
    int cyc = 0;
    bit hist[SS];
    bit s_cur, s_prev, measuring, pend;
    int t_rise, hi_acc, busy_end, pend_due, pend_p, pend_h, pend_q;
    int e_duty, e_per, e_high;
    bit e_vld, e_ovr, e_stuck, e_busy;

    always @(posedge clk) begin
        bit rise, busy_now;
        cyc++;
        if (!rst_n) begin
            for (int i = 0; i < SS; i++) hist[i] = 1'b0;
            s_cur = 0; s_prev = 0; measuring = 0; pend = 0;
            busy_end = -100; e_duty = 0; e_per = 0; e_high = 0;
            e_vld = 0; e_ovr = 0; e_stuck = 0;
        end else begin
            e_vld    = 0;
            e_ovr    = 0;
            rise     = s_cur && !s_prev;
            busy_now = (cyc <= busy_end);
            if (pend && cyc == pend_due) begin
                e_duty = pend_q; e_per = pend_p; e_high = pend_h;
                e_stuck = 0; e_vld = 1; pend = 0;
            end
            if (measuring) begin
                if (rise) begin
                    if (busy_now) begin
                        e_ovr = 1;
                    end else begin
                        pend_p   = (cyc - t_rise > MAXV) ? MAXV : cyc - t_rise;
                        pend_h   = (hi_acc > MAXV) ? MAXV : hi_acc;
                        pend_q   = (pend_h * (1 << DW)) / pend_p;
                        pend     = 1;
                        pend_due = cyc + DW;
                        busy_end = cyc + DW;
                    end
                    t_rise = cyc;
                    hi_acc = 1;
                end else begin
                    if (s_cur) hi_acc++;
                    if ((cyc - t_rise >= MAXV) && !busy_now) begin
                        e_duty = s_cur ? (1 << DW) - 1 : 0;
                        e_per = 0; e_high = 0; e_stuck = 1; e_vld = 1;
                        measuring = 0;
                    end
                end
            end else if (rise) begin
                measuring = 1;
                t_rise    = cyc;
                hi_acc    = 1;
            end
            s_prev = s_cur;
            for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = pwm_in;
            s_cur   = hist[SS-1];
        end
        e_busy = (cyc < busy_end);
    end

    // ---------------- compare / monitor ----------------
    int vld_cnt = 0, ovr_cnt = 0, vld_edge = 0;
    int last_duty = 0, last_per = 0, last_high = 0, last_stuck = 0;

    always @(posedge clk) begin
        #1;
        chk("valid",   int'(cap_if.valid),      int'(e_vld));
        chk("overrun", int'(cap_if.overrun),    int'(e_ovr));
        chk("busy",    int'(cap_if.busy),       int'(e_busy));
        chk("stuck",   int'(cap_if.stuck),      int'(e_stuck));
        chk("duty",    int'(cap_if.duty_out),   e_duty);
        chk("period",  int'(cap_if.period_out), e_per);
        chk("high",    int'(cap_if.high_out),   e_high);
        if (cap_if.valid) begin
            vld_cnt++;
            vld_edge   = cyc;
            last_duty  = int'(cap_if.duty_out);
            last_per   = int'(cap_if.period_out);
            last_high  = int'(cap_if.high_out);
            last_stuck = int'(cap_if.stuck);
        end
        if (cap_if.overrun) ovr_cnt++;
    end

    // ---------------- stimulus ----------------
    int rise_edge = 0;

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pwm(input int hi, input int per, input int n);
        for (int k = 0; k < n; k++) begin
            pwm_in    = 1'b1;
            rise_edge = cyc + 1;
            hold(hi);
            pwm_in    = 1'b0;
            hold(per - hi);
        end
    endtask

    task automatic chk_result(input string nm, input int d, input int p, input int h, input int st);
        chk({nm, "_duty"},   last_duty,  d);
        chk({nm, "_period"}, last_per,   p);
        chk({nm, "_high"},   last_high,  h);
        chk({nm, "_stuck"},  last_stuck, st);
    endtask

    initial begin
        int v0, o0;
        @(negedge clk);
        // 1: reset held with pwm_in toggling, then a single rise
        for (int i = 0; i < 4; i++) begin
            pwm_in = ~pwm_in;
            hold(1);
        end
        chk("rst_duty", int'(cap_if.duty_out), 0);
        chk("rst_busy", int'(cap_if.busy), 0);
        chk("rst_no_valid", vld_cnt + ovr_cnt, 0);
        pwm_in = 1'b0;
        rst_n  = 1'b1;
        hold(5);
        v0 = vld_cnt; o0 = ovr_cnt;
        pwm_in = 1'b1; hold(20);
        pwm_in = 1'b0; hold(20);
        chk("single_rise_no_valid", vld_cnt - v0, 0);
        chk("single_rise_no_ovr",   ovr_cnt - o0, 0);

        // 2: generator Dutycycle=64, period 256
        pwm(64, 256, 4);
        chk_result("d64", 64, 256, 64, 0);
        chk("d64_latency", vld_edge + 1 - rise_edge, SS + DW + 1);

        // 3: directed sweep
        pwm(1, 256, 3);
        chk_result("d1", 1, 256, 1, 0);
        pwm(255, 256, 3);
        chk_result("d255", 255, 256, 255, 0);
        pwm(33, 100, 3);
        chk_result("d33of100", 84, 100, 33, 0);
        v0 = vld_cnt;
        hold(MAXV + 100);
        chk_result("no_more_rises", 0, 0, 0, 1);
        chk("no_more_rises_valids", vld_cnt - v0, 1);

        // 4: stuck high, stuck low, then recovery
        v0 = vld_cnt;
        pwm_in = 1'b1; hold(MAXV + 100);
        chk_result("stuck_hi", 255, 0, 0, 1);
        chk("stuck_hi_valids", vld_cnt - v0, 1);
        pwm_in = 1'b0; hold(10);
        pwm_in = 1'b1; hold(10);
        pwm_in = 1'b0; hold(MAXV + 100);
        chk_result("stuck_lo", 0, 0, 0, 1);
        pwm(64, 256, 3);
        chk_result("recover", 64, 256, 64, 0);

        // 5: period shorter than the divider -> overruns
        o0 = ovr_cnt;
        pwm(3, 6, 20);
        chk_result("fast", 128, 6, 3, 0);
        chk("fast_overrun_seen", (ovr_cnt - o0 > 0) ? 1 : 0, 1);
        hold(20);

        // 6: reset pulse while the divider is busy
        pwm_in = 1'b1;
        hold(5);
        rst_n = 1'b0;
        hold(1);
        rst_n = 1'b1;
        v0 = vld_cnt;
        hold(1);
        chk("rst6_busy",   int'(cap_if.busy), 0);
        chk("rst6_duty",   int'(cap_if.duty_out), 0);
        chk("rst6_period", int'(cap_if.period_out), 0);
        hold(57);
        pwm_in = 1'b0;
        hold(192);
        chk("rst6_no_valid", vld_cnt - v0, 0);
        pwm(64, 256, 3);
        chk_result("after_rst", 64, 256, 64, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
